// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative shift-add multiply / restoring divide with HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier magnitude is zero.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mc;
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg;
    logic               neg_r;
    logic               dbz;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               last;

    assign busy = state != IDLE;

    // Operand magnitudes, restoring-divide trial subtraction and loop exit condition
    always_comb begin
        sa      = ~op[0] & op_a[WIDTH-1];
        sb      = ~op[0] & op_b[WIDTH-1];
        mag_a   = sa ? -op_a : op_a;
        mag_b   = sb ? -op_b : op_b;
        shifted = {acc[WIDTH-1:0], y[WIDTH-1]};
        diff    = shifted - {1'b0, mc[WIDTH-1:0]};
`ifdef MULDIV_EARLY_OUT_EN
        last    = cnt == CNT_W'(1) || (!is_div && y[WIDTH-1:1] == '0);
`else
        last    = cnt == CNT_W'(1);
`endif
    end

    // IDLE -> CALC -> FIX controller with datapath; hi/lo written only at FIX or by MTHI/MTLO
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        state       <= CALC;
                        cnt         <= CNT_W'(WIDTH);
                        is_div      <= op[1];
                        neg         <= sa ^ sb;
                        neg_r       <= sa;
                        dbz         <= op[1] && op_b == '0;
                        div_by_zero <= op[1] && op_b == '0;
                        a_raw       <= op_a;
                        acc         <= '0;
                        mc          <= {{WIDTH{1'b0}}, op[1] ? mag_b : mag_a};
                        y           <= op[1] ? mag_a : mag_b;
                    end else if (start && op[2:1] == 2'b10) begin
                        if (op[0]) lo <= op_a;
                        else       hi <= op_a;
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        acc[WIDTH-1:0] <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                        y              <= {y[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        if (y[0]) acc <= acc + mc;
                        mc <= mc << 1;
                        y  <= y >> 1;
                    end
                    if (last) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= neg ? -acc : acc;
                    end else if (dbz) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        lo <= neg ? -y : y;
                        hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed and random checks of mips_muldiv_unit against an arithmetic model.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {div_by_zero, hi, lo} from plain integer arithmetic
    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd3: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: p = '0;
        endcase
        return {o[1] && b == 0, p};
    endfunction

    // cycle (counted from the start edge) in which done is expected
    function automatic int lat(input logic [2:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          k;
        m = (o == 3'd0 && b[31]) ? -b : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) return (k < 1 ? 1 : k) + 2;
`endif
        return 34;
    endfunction

    // issue one mul/div in the current cycle and follow it to its done pulse
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] e;
        logic [63:0] held;
        int          n;
        e = model(o, a, b);
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; op = 3'($urandom_range(0, 3));
        held = {hi, lo};
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        n = 1;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 3) chk({tag, "_hold"}, {hi, lo}, held);
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat(o, b)));
        chk({tag, "_hilo"}, {hi, lo}, e[63:0]);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(e[64]));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        {m_hi, m_lo} = e[63:0];
    endtask

    initial begin
        logic        seen;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_spec", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run("mult_neg", 3'd0, -32'sd7, 32'd3);
        chk("mult_neg_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run("div_neg", 3'd2, -32'sd7, 32'd2);
        chk("div_neg_spec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_spec", {hi, lo}, 64'h0000_0000_8000_0000);
        run("divu_zero", 3'd3, 32'd100, 32'd0);
        chk("divu_zero_spec", {31'd0, div_by_zero, lo}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        run("div_zero", 3'd2, -32'sd5, 32'd0);
        run("divu_7", 3'd3, 32'd100, 32'd7);
        chk("divu_7_spec", {hi, lo}, {32'd2, 32'd14});
        run("multu_9x3", 3'd1, 32'd9, 32'd3);
        run("mult_b0", 3'd0, 32'd12345, 32'd0);
        run("mult_bneg", 3'd0, 32'd77, -32'sd1);
        // MTHI / MTLO / unlisted op in IDLE
        op = 3'd4; op_a = 32'h1234; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd5; op_a = 32'h5678;
        chk("mthi", {hi, lo}, {32'h1234, m_lo});
        chk("mthi_ctl", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        op = 3'd6; op_a = 32'hDEAD;
        chk("mtlo", {hi, lo}, {32'h1234, 32'h5678});
        chk("mtlo_ctl", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("noop", {hi, lo}, {32'h1234, 32'h5678});
        chk("noop_ctl", {62'd0, busy, done}, 64'd0);
        // random operations, each issued in the previous operation's done cycle
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1, 2: b = 32'($urandom_range(1, 40));
                3: b = -32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            run($sformatf("rnd%0d_op%0d", i, o), o, a, b);
        end
        // start while busy is ignored; reset discards the in-flight op
        op = 3'd1; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op = 3'd3; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_ignore", {62'd0, busy, done}, 64'd2);
        chk("busy_hold", {hi, lo}, {m_hi, m_lo});
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("midrst_quiet", 64'(seen), 64'd0);
        chk("midrst_keep", {hi, lo}, 64'd0);
        run("post_rst", 3'd1, 32'd9, 32'd3);
        chk("post_rst_spec", 64'(lo), 64'd27);
        run("b2b", 3'd0, -32'sd100, -32'sd100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
